// File: rtl/instruction_loader.sv
// Byte-stream program loader: writes UART bytes to instruction memory from address 0
// and stops on an aligned halt word or on overflow. Optional inactivity timeout: LOADER_TIMEOUT_EN.
module instruction_loader #(
  parameter int                      NB_DATA        = 8,
  parameter int                      NB_ADDR_DEPTH  = 8,
  parameter int                      MEMORY_DEPTH   = 256,
  parameter int                      NB_INSTRUCTION = 32,
  parameter logic [NB_INSTRUCTION-1:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int                      TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic [NB_DATA-1:0]       i_rx_data,
  input  logic                     i_rx_valid,
  output logic                     o_write_enable,
  output logic [NB_ADDR_DEPTH-1:0] o_write_addr,
  output logic [NB_DATA-1:0]       o_write_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [NB_ADDR_DEPTH-2:0] o_word_count,
  output logic [1:0]               o_dbg_state
);

  // Handshake: a byte is accepted when i_rx_valid is high in RECEIVE and i_start is low;
  // there is no backpressure, every accepted byte produces exactly one write strobe.

  localparam int BYTES_PER_WORD = NB_INSTRUCTION / NB_DATA;
  localparam int WORD_LSB       = $clog2(BYTES_PER_WORD);
  localparam int SH_W           = NB_INSTRUCTION - NB_DATA;
  localparam logic [NB_ADDR_DEPTH-1:0] LAST_ADDR = NB_ADDR_DEPTH'(MEMORY_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [NB_ADDR_DEPTH-1:0]   ptr_q, ptr_d;
  logic [SH_W-1:0]            word_q, word_d;
  logic                       we_q, we_d;
  logic [NB_ADDR_DEPTH-1:0]   addr_q, addr_d;
  logic [NB_DATA-1:0]         data_q, data_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic [NB_ADDR_DEPTH-2:0]   count_q, count_d;

  logic accept;
  logic word_end;
  logic halt_hit;
  logic error_set;
  logic timeout_hit;

  assign accept   = (state_q == ST_RECEIVE) && i_rx_valid && !i_start;
  assign word_end = accept && (ptr_q[WORD_LSB-1:0] == {WORD_LSB{1'b1}});
  // The word register only keeps the three older bytes; the current byte completes the compare.
  assign halt_hit = word_end && ({word_q, i_rx_data} == HALT_WORD);

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TMO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] tmo_q, tmo_d;

  assign timeout_hit = (state_q == ST_RECEIVE) && !i_start && !i_rx_valid && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = tmo_q;
    if (i_start || accept) begin
      tmo_d = '0;
    end else if (state_q == ST_RECEIVE) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign error_set = (word_end && !halt_hit && (ptr_q == LAST_ADDR)) || timeout_hit;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = ST_RECEIVE;
    end else if (halt_hit) begin
      state_d = ST_DONE;
    end else if (error_set) begin
      state_d = ST_ERROR;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    count_d = count_q;
    if (i_start) begin
      ptr_d   = '0;
      word_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else if (accept) begin
      we_d   = 1'b1;
      addr_d = ptr_q;
      data_d = i_rx_data;
      ptr_d  = ptr_q + 1'b1;
      word_d = {word_q[SH_W-NB_DATA-1:0], i_rx_data};
      if (word_end) begin
        count_d = count_q + 1'b1;
      end
      if (halt_hit) begin
        done_d = 1'b1;
      end else if (error_set) begin
        error_d = 1'b1;
      end
    end else if (timeout_hit) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  assign o_write_enable = we_q;
  assign o_write_addr   = addr_q;
  assign o_write_data   = data_q;
  assign o_busy         = (state_q == ST_RECEIVE);
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_word_count   = count_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed program loads plus random byte
// streams, checked every cycle against a received-byte-list model.
module tb_instruction_loader;

  localparam int DEPTH = 256;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int TMO = 16;

  logic       i_clock;
  logic       i_reset_n;
  logic       i_start;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_write_enable;
  logic [7:0] o_write_addr;
  logic [7:0] o_write_data;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [6:0] o_word_count;
  logic [1:0] o_dbg_state;

  instruction_loader #(
    .NB_DATA        (8),
    .NB_ADDR_DEPTH  (8),
    .MEMORY_DEPTH   (DEPTH),
    .NB_INSTRUCTION (32),
    .HALT_WORD      (HALT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock        (i_clock),
    .i_reset_n      (i_reset_n),
    .i_start        (i_start),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_write_enable (o_write_enable),
    .o_write_addr   (o_write_addr),
    .o_write_data   (o_write_data),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_word_count   (o_word_count),
    .o_dbg_state    (o_dbg_state)
  );

  // clock / reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: the list of bytes accepted since the last start
  logic [7:0]  rcv[$];
  logic [15:0] exp_q[$];
  bit          m_active;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_done;
  logic        m_err;
  logic [6:0]  m_count;
  int          idle_n;

  always @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_active = 0; m_we = 0; m_addr = 0; m_data = 0;
      m_done = 0; m_err = 0; m_count = 0; idle_n = 0;
      rcv.delete();
      exp_q.delete();
    end else begin
      m_we = 0;
      if (i_start) begin
        m_active = 1; m_done = 0; m_err = 0; m_count = 0; idle_n = 0;
        rcv.delete();
      end else if (m_active) begin
        if (i_rx_valid) begin
          int n;
          rcv.push_back(i_rx_data);
          n = rcv.size();
          m_we = 1;
          m_addr = 8'(n - 1);
          m_data = i_rx_data;
          exp_q.push_back({m_addr, m_data});
          idle_n = 0;
          if (n % 4 == 0) begin
            m_count = 7'(n / 4);
            if ({rcv[n-4], rcv[n-3], rcv[n-2], rcv[n-1]} == HALT) begin
              m_done = 1; m_active = 0;
            end else if (n == DEPTH) begin
              m_err = 1; m_active = 0;
            end
          end
        end else begin
`ifdef LOADER_TIMEOUT_EN
          idle_n++;
          if (idle_n == TMO) begin
            m_err = 1; m_active = 0;
          end
`endif
        end
      end
    end
  end

  // per-cycle compare plus write scoreboard
  always @(negedge i_clock) begin
    chk("write_enable", {31'd0, o_write_enable}, {31'd0, m_we});
    chk("write_addr",   {24'd0, o_write_addr},   {24'd0, m_addr});
    chk("write_data",   {24'd0, o_write_data},   {24'd0, m_data});
    chk("busy",         {31'd0, o_busy},         {31'd0, m_active});
    chk("done",         {31'd0, o_done},         {31'd0, m_done});
    chk("error",        {31'd0, o_error},        {31'd0, m_err});
    chk("word_count",   {25'd0, o_word_count},   {25'd0, m_count});
    if (o_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_write", {16'd0, o_write_addr, o_write_data}, {16'd0, e});
      end
    end
  end

  // driver: called at posedge+1, applies inputs for one sampling edge, returns at posedge+1
  task automatic drive_cycle(input logic s, input logic v, input logic [7:0] d);
    i_start = s; i_rx_valid = v; i_rx_data = d;
    @(posedge i_clock); #1;
    i_start = 0; i_rx_valid = 0; i_rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(0, 0, 8'h00);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_we"},    {31'd0, o_write_enable}, 32'd0);
    chk({nm, "_addr"},  {24'd0, o_write_addr},   32'd0);
    chk({nm, "_data"},  {24'd0, o_write_data},   32'd0);
    chk({nm, "_busy"},  {31'd0, o_busy},         32'd0);
    chk({nm, "_done"},  {31'd0, o_done},         32'd0);
    chk({nm, "_error"}, {31'd0, o_error},        32'd0);
    chk({nm, "_count"}, {25'd0, o_word_count},   32'd0);
  endtask

  logic [7:0] prog[8]  = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] strad[8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    i_reset_n = 0; i_start = 0; i_rx_valid = 0; i_rx_data = 0;
    repeat (3) @(posedge i_clock);
    #1;
    chk_all_zero("reset");
    i_reset_n = 1;

    drive_cycle(0, 1, 8'hAA);
    chk("idle_ignored_we", {31'd0, o_write_enable}, 32'd0);

    // spaced program
    drive_cycle(1, 0, 8'h00);
    chk("start_busy", {31'd0, o_busy}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      drive_cycle(0, 1, prog[k]);
      chk("spaced_we",   {31'd0, o_write_enable}, 32'd1);
      chk("spaced_addr", {24'd0, o_write_addr}, k);
      chk("spaced_data", {24'd0, o_write_data}, {24'd0, prog[k]});
      if (k < 7) idle(9);
    end
    chk("spaced_done",  {31'd0, o_done}, 32'd1);
    chk("spaced_count", {25'd0, o_word_count}, 32'd2);
    chk("spaced_busy",  {31'd0, o_busy}, 32'd0);
    idle(1);
    chk("hold_we",   {31'd0, o_write_enable}, 32'd0);
    chk("hold_addr", {24'd0, o_write_addr}, 32'd7);

    // back-to-back program
    drive_cycle(1, 0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      drive_cycle(0, 1, prog[k]);
      chk("b2b_we",   {31'd0, o_write_enable}, 32'd1);
      chk("b2b_addr", {24'd0, o_write_addr}, k);
    end
    chk("b2b_done", {31'd0, o_done}, 32'd1);
    chk("b2b_count", {25'd0, o_word_count}, 32'd2);

    // overflow: 256 zero bytes
    drive_cycle(1, 0, 8'h00);
    for (int k = 0; k < DEPTH; k++) drive_cycle(0, 1, 8'h00);
    chk("ovf_error", {31'd0, o_error}, 32'd1);
    chk("ovf_done",  {31'd0, o_done}, 32'd0);
    chk("ovf_count", {25'd0, o_word_count}, 32'd64);
    chk("ovf_addr",  {24'd0, o_write_addr}, 32'd255);
    drive_cycle(0, 1, 8'h33);
    chk("ovf_extra_we", {31'd0, o_write_enable}, 32'd0);
    chk("ovf_extra_count", {25'd0, o_word_count}, 32'd64);

    // 0xFF run straddling a word boundary
    drive_cycle(1, 0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      drive_cycle(0, 1, strad[k]);
      if (k == 4) chk("strad_done_b5", {31'd0, o_done}, 32'd0);
    end
    chk("strad_done_b8", {31'd0, o_done}, 32'd1);
    chk("strad_count",   {25'd0, o_word_count}, 32'd2);

    // reset in the middle of a write strobe
    drive_cycle(1, 0, 8'h00);
    for (int k = 0; k < 3; k++) drive_cycle(0, 1, 8'(k + 1));
    chk("pre_reset_we", {31'd0, o_write_enable}, 32'd1);
    #2 i_reset_n = 0;
    #1 chk_all_zero("midreset");
    repeat (2) @(posedge i_clock);
    #1 i_reset_n = 1;
    drive_cycle(0, 1, 8'h11);
    chk("post_reset_ignored", {31'd0, o_write_enable}, 32'd0);
    drive_cycle(1, 0, 8'h00);
    drive_cycle(0, 1, 8'h42);
    chk("reload_addr", {24'd0, o_write_addr}, 32'd0);
    chk("reload_data", {24'd0, o_write_data}, 32'h42);

    // inactivity
    drive_cycle(1, 0, 8'h00);
    drive_cycle(0, 1, 8'h5A);
`ifdef LOADER_TIMEOUT_EN
    idle(TMO - 1);
    chk("tmo_error_early", {31'd0, o_error}, 32'd0);
    idle(1);
    chk("tmo_error", {31'd0, o_error}, 32'd1);
    chk("tmo_busy",  {31'd0, o_busy}, 32'd0);
`else
    idle(40);
    chk("no_tmo_error", {31'd0, o_error}, 32'd0);
    chk("no_tmo_busy",  {31'd0, o_busy}, 32'd1);
`endif

    // random streams, including starts colliding with bytes
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       drive_cycle(1, 0, 8'h00);
      else if (r < 5)  drive_cycle(1, 1, 8'($urandom));
      else if (r < 70) drive_cycle(0, 1, ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom));
      else             drive_cycle(0, 0, 8'($urandom));
    end

    idle(4);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
